issue_ctrl: RTL and testbench

- Decode-side issue controller that sequences the register/predicate scoreboard.
- Holds one 4-lane decoded packet. Checks its sources (RAW) and destinations (WAW) against the scoreboard, stalls until all hazards clear and execute is ready, then issues the packet.
- On issue, drives the scoreboard set inputs (d2pc_out_* equivalents), so pending bits are visible the cycle after issue.
- Includes a stall watchdog that flags pipeline deadlock.

---
 rtl/issue_ctrl_pkg.sv | 9 +
 rtl/issue_ctrl_hazard_check.sv | 31 +++
 rtl/issue_ctrl.sv | 104 ++++++++++
 tb/tb_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared lane geometry and issue FSM state encoding
package issue_ctrl_pkg;
  localparam int NUM_LANES = 4;
  localparam int SRCS_PER_LANE = 2;
  localparam int REG_W = 5;
  localparam int PRED_W = 2;
  localparam logic [PRED_W-1:0] PRED_NONE = 2'd3;
  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;
endpackage

// File: rtl/issue_ctrl_hazard_check.sv
// ic_hazard_check: RAW/WAW hazard detection of a held packet against the reg/pred scoreboards
// Ports: src_num/src_use, pred_num, rd_num/rd_we/pred_we (packet), reg_sb/pred_sb (pending writes), hazard (out)
module ic_hazard_check
  import issue_ctrl_pkg::*;
(
  input  logic [39:0] src_num,
  input  logic [7:0]  src_use,
  input  logic [7:0]  pred_num,
  input  logic [19:0] rd_num,
  input  logic [3:0]  rd_we,
  input  logic [3:0]  pred_we,
  input  logic [31:0] reg_sb,
  input  logic [2:0]  pred_sb,
  output logic        hazard
);
  // predicate 3 means "none" and has no scoreboard bit, so pad it with a zero
  logic [3:0] pred_sb_x;
  assign pred_sb_x = {1'b0, pred_sb};
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = 0; j < SRCS_PER_LANE; j++)
        hazard |= src_use[SRCS_PER_LANE*i+j]
                & (src_num[REG_W*(SRCS_PER_LANE*i+j)+:REG_W] != '0)
                & reg_sb[src_num[REG_W*(SRCS_PER_LANE*i+j)+:REG_W]];
      hazard |= (pred_num[PRED_W*i+:PRED_W] != PRED_NONE) & pred_sb_x[pred_num[PRED_W*i+:PRED_W]];
      hazard |= rd_we[i] & (rd_num[REG_W*i+:REG_W] != '0) & reg_sb[rd_num[REG_W*i+:REG_W]];
      hazard |= pred_we[i] & pred_sb_x[rd_num[REG_W*i+:PRED_W]];
    end
  end
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: holds one decoded 4-lane packet, stalls on scoreboard hazards, issues and sets scoreboard
// Ports: clkrst_core_clk/clkrst_core_rst_n (sync active-low); d2ic_* packet in with ic2d_ready;
//   sb2d_* scoreboards; ex2ic_ready; ctl2ic_flush; ic2ex_valid issue strobe; ic2sb_* scoreboard set;
//   ic2ctl_stall/deadlock/stall_cycles status.
// Optional: IC_PERF_CTR_EN builds the 32-bit stall-cycle counter; otherwise ic2ctl_stall_cycles is 0.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 1024,
  parameter int STALL_W = 11
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic        d2ic_valid,
  output logic        ic2d_ready,
  input  logic [39:0] d2ic_src_num,
  input  logic [7:0]  d2ic_src_use,
  input  logic [7:0]  d2ic_pred_num,
  input  logic [19:0] d2ic_rd_num,
  input  logic [3:0]  d2ic_rd_we,
  input  logic [3:0]  d2ic_pred_we,
  input  logic [31:0] sb2d_reg_scoreboard,
  input  logic [2:0]  sb2d_pred_scoreboard,
  input  logic        ex2ic_ready,
  input  logic        ctl2ic_flush,
  output logic        ic2ex_valid,
  output logic [19:0] ic2sb_rd_num,
  output logic [3:0]  ic2sb_rd_we,
  output logic [3:0]  ic2sb_pred_we,
  output logic        ic2ctl_stall,
  output logic        ic2ctl_deadlock,
  output logic [31:0] ic2ctl_stall_cycles
);
  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] LIMIT_M1 = STALL_W'(STALL_LIMIT - 1);
  state_t state, state_nxt;
  logic [39:0] src_num_q;
  logic [7:0] src_use_q, pred_num_q;
  logic [19:0] rd_num_q;
  logic [3:0] rd_we_q, pred_we_q;
  logic hazard, issue, accept;
  logic [STALL_W-1:0] stall_cnt;
  ic_hazard_check u_hazard (
    .src_num(src_num_q),
    .src_use(src_use_q),
    .pred_num(pred_num_q),
    .rd_num(rd_num_q),
    .rd_we(rd_we_q),
    .pred_we(pred_we_q),
    .reg_sb(sb2d_reg_scoreboard),
    .pred_sb(sb2d_pred_scoreboard),
    .hazard(hazard)
  );
  always_ff @(posedge clkrst_core_clk)
    state <= !clkrst_core_rst_n ? EMPTY : state_nxt;
  always_comb
    state_nxt = ctl2ic_flush ? EMPTY : accept ? HELD : issue ? EMPTY : state;
  always_comb begin
    issue = (state == HELD) & ~hazard & ex2ic_ready & ~ctl2ic_flush;
    ic2d_ready = ((state == EMPTY) | issue) & ~ctl2ic_flush;
    accept = d2ic_valid & ic2d_ready;
    ic2ex_valid = issue;
    ic2ctl_stall = (state == HELD) & ~issue & ~ctl2ic_flush;
    ic2sb_rd_num = (state == HELD) ? rd_num_q : '0;
    ic2sb_rd_we = issue ? rd_we_q : '0;
    ic2sb_pred_we = issue ? pred_we_q : '0;
  end
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      src_num_q <= '0;
      src_use_q <= '0;
      pred_num_q <= '0;
      rd_num_q <= '0;
      rd_we_q <= '0;
      pred_we_q <= '0;
    end else if (accept) begin
      src_num_q <= d2ic_src_num;
      src_use_q <= d2ic_src_use;
      pred_num_q <= d2ic_pred_num;
      rd_num_q <= d2ic_rd_num;
      rd_we_q <= d2ic_rd_we;
      pred_we_q <= d2ic_pred_we;
    end
  end
  // deadlock sets on the same edge the counter reaches the limit; flush implies no stall, so it clears both
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      stall_cnt <= '0;
      ic2ctl_deadlock <= 1'b0;
    end else begin
      stall_cnt <= !ic2ctl_stall ? '0 : (stall_cnt == LIMIT) ? stall_cnt : stall_cnt + 1'b1;
      ic2ctl_deadlock <= ~ctl2ic_flush & (ic2ctl_deadlock | (ic2ctl_stall & (stall_cnt >= LIMIT_M1)));
    end
  end
`ifdef IC_PERF_CTR_EN
  logic [31:0] perf_q;
  always_ff @(posedge clkrst_core_clk)
    if (!clkrst_core_rst_n) perf_q <= '0;
    else if (ic2ctl_stall) perf_q <= perf_q + 1'b1;
  assign ic2ctl_stall_cycles = perf_q;
`else
  assign ic2ctl_stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed self-checking bench for issue_ctrl
module tb_issue_ctrl;
  logic clk, rst_n, d2ic_valid, ic2d_ready, ex2ic_ready, ctl2ic_flush;
  logic [39:0] src_num;
  logic [7:0] src_use, pred_num;
  logic [19:0] rd_num;
  logic [3:0] rd_we, pred_we;
  logic [31:0] sb_reg;
  logic [2:0] sb_pred;
  logic ic2ex_valid, ic2ctl_stall, ic2ctl_deadlock;
  logic [19:0] ic2sb_rd_num;
  logic [3:0] ic2sb_rd_we, ic2sb_pred_we;
  logic [31:0] ic2ctl_stall_cycles, perf_exp;
  int total = 0;
  int bad = 0;
  issue_ctrl #(.STALL_LIMIT(4), .STALL_W(11)) dut (
    .clkrst_core_clk(clk),
    .clkrst_core_rst_n(rst_n),
    .d2ic_valid(d2ic_valid),
    .ic2d_ready(ic2d_ready),
    .d2ic_src_num(src_num),
    .d2ic_src_use(src_use),
    .d2ic_pred_num(pred_num),
    .d2ic_rd_num(rd_num),
    .d2ic_rd_we(rd_we),
    .d2ic_pred_we(pred_we),
    .sb2d_reg_scoreboard(sb_reg),
    .sb2d_pred_scoreboard(sb_pred),
    .ex2ic_ready(ex2ic_ready),
    .ctl2ic_flush(ctl2ic_flush),
    .ic2ex_valid(ic2ex_valid),
    .ic2sb_rd_num(ic2sb_rd_num),
    .ic2sb_rd_we(ic2sb_rd_we),
    .ic2sb_pred_we(ic2sb_pred_we),
    .ic2ctl_stall(ic2ctl_stall),
    .ic2ctl_deadlock(ic2ctl_deadlock),
    .ic2ctl_stall_cycles(ic2ctl_stall_cycles)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pkt(input logic [39:0] sn, input logic [7:0] su, input logic [7:0] pn,
                     input logic [19:0] rn, input logic [3:0] rw, input logic [3:0] pw);
    src_num = sn;
    src_use = su;
    pred_num = pn;
    rd_num = rn;
    rd_we = rw;
    pred_we = pw;
  endtask
  initial begin
`ifdef IC_PERF_CTR_EN
    perf_exp = 32'd4;
`else
    perf_exp = 32'd0;
`endif
    rst_n = 1'b0;
    d2ic_valid = 1'b0;
    ex2ic_ready = 1'b1;
    ctl2ic_flush = 1'b0;
    sb_reg = '0;
    sb_pred = '0;
    pkt('0, '0, 8'hFF, '0, '0, '0);
    tick;
    tick;
    chk("rst_ready", 32'(ic2d_ready), 1);
    chk("rst_valid", 32'(ic2ex_valid), 0);
    chk("rst_stall", 32'(ic2ctl_stall), 0);
    chk("rst_deadlock", 32'(ic2ctl_deadlock), 0);
    chk("rst_rd_num", 32'(ic2sb_rd_num), 0);
    chk("rst_we", 32'({ic2sb_rd_we, ic2sb_pred_we}), 0);
    chk("rst_perf", ic2ctl_stall_cycles, 0);
    rst_n = 1'b1;
    // watchdog: permanent RAW hazard on r3
    sb_reg = 32'h8;
    pkt(40'h3, 8'h01, 8'hFF, 20'h5, 4'b0001, 4'b0000);
    d2ic_valid = 1'b1;
    #1 chk("wd_ready", 32'(ic2d_ready), 1);
    tick;
    d2ic_valid = 1'b0;
    #1 chk("wd_stall", 32'(ic2ctl_stall), 1);
    chk("wd_noissue", 32'(ic2ex_valid), 0);
    chk("wd_busy", 32'(ic2d_ready), 0);
    tick;
    tick;
    tick;
    chk("wd_dl_early", 32'(ic2ctl_deadlock), 0);
    tick;
    chk("wd_dl_set", 32'(ic2ctl_deadlock), 1);
    chk("wd_perf", ic2ctl_stall_cycles, perf_exp);
    ctl2ic_flush = 1'b1;
    #1 chk("fl_ready", 32'(ic2d_ready), 0);
    chk("fl_valid", 32'(ic2ex_valid), 0);
    chk("fl_stall", 32'(ic2ctl_stall), 0);
    tick;
    ctl2ic_flush = 1'b0;
    #1 chk("fl_dl_clr", 32'(ic2ctl_deadlock), 0);
    chk("fl_empty", 32'(ic2d_ready), 1);
    chk("fl_rd_num", 32'(ic2sb_rd_num), 0);
    chk("fl_valid2", 32'(ic2ex_valid), 0);
    chk("fl_perf", ic2ctl_stall_cycles, perf_exp);
    sb_reg = '0;
    // clean issue
    pkt(40'h83, 8'h03, 8'hFF, 20'h5, 4'b0001, 4'b0000);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("cl_valid", 32'(ic2ex_valid), 1);
    chk("cl_rd_we", 32'(ic2sb_rd_we), 32'h1);
    chk("cl_rd_num", 32'(ic2sb_rd_num[4:0]), 5);
    chk("cl_stall", 32'(ic2ctl_stall), 0);
    tick;
    chk("cl_done", 32'(ic2ex_valid), 0);
    chk("cl_rd_we0", 32'(ic2sb_rd_we), 0);
    chk("cl_rd_num0", 32'(ic2sb_rd_num), 0);
    // RAW stall then clear
    sb_reg = 32'h8;
    pkt(40'h3, 8'h01, 8'hFF, 20'h6, 4'b0001, 4'b0000);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("raw_stall", 32'(ic2ctl_stall), 1);
    chk("raw_noissue", 32'(ic2ex_valid), 0);
    chk("raw_rd_we0", 32'(ic2sb_rd_we), 0);
    tick;
    chk("raw_stall2", 32'(ic2ctl_stall), 1);
    sb_reg = '0;
    #1 chk("raw_issue", 32'(ic2ex_valid), 1);
    chk("raw_rd_we", 32'(ic2sb_rd_we), 32'h1);
    tick;
    chk("raw_done", 32'(ic2ex_valid), 0);
    // r0 never hazards (source and destination)
    sb_reg = 32'h1;
    pkt(40'h0, 8'h01, 8'hFF, 20'h0, 4'b0001, 4'b0000);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("r0_issue", 32'(ic2ex_valid), 1);
    chk("r0_stall", 32'(ic2ctl_stall), 0);
    tick;
    sb_reg = '0;
    // lane2 predicate p2 pending
    sb_pred = 3'b100;
    pkt('0, '0, 8'hEF, '0, '0, '0);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("pr_stall", 32'(ic2ctl_stall), 1);
    tick;
    chk("pr_stall2", 32'(ic2ctl_stall), 1);
    sb_pred = '0;
    #1 chk("pr_issue", 32'(ic2ex_valid), 1);
    tick;
    // unpredicated never stalls
    sb_pred = 3'b111;
    pkt('0, '0, 8'hFF, '0, '0, '0);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("pn3_issue", 32'(ic2ex_valid), 1);
    tick;
    // predicate WAW: lane1 writes p1
    sb_pred = 3'b010;
    pkt('0, '0, 8'hFF, 20'h20, 4'b0000, 4'b0010);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("pw_stall", 32'(ic2ctl_stall), 1);
    chk("pw_we0", 32'(ic2sb_pred_we), 0);
    sb_pred = '0;
    #1 chk("pw_issue", 32'(ic2ex_valid), 1);
    chk("pw_we", 32'(ic2sb_pred_we), 32'h2);
    chk("pw_rd_num", 32'(ic2sb_rd_num), 32'h20);
    tick;
    // GPR WAW on lane3 r7, then execute back-pressure
    sb_reg = 32'h80;
    pkt('0, '0, 8'hFF, 20'h38000, 4'b1000, 4'b0000);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("waw_stall", 32'(ic2ctl_stall), 1);
    sb_reg = '0;
    ex2ic_ready = 1'b0;
    #1 chk("exr_stall", 32'(ic2ctl_stall), 1);
    chk("exr_noissue", 32'(ic2ex_valid), 0);
    ex2ic_ready = 1'b1;
    #1 chk("waw_issue", 32'(ic2ex_valid), 1);
    chk("waw_rd_we", 32'(ic2sb_rd_we), 32'h8);
    tick;
    // back-to-back, one packet per cycle
    d2ic_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pkt('0, '0, 8'hFF, 20'(k), 4'b0001, 4'b0000);
      #1 chk("b2b_ready", 32'(ic2d_ready), 1);
      if (k > 1) begin
        chk("b2b_valid", 32'(ic2ex_valid), 1);
        chk("b2b_rd_num", 32'(ic2sb_rd_num), 32'(k - 1));
      end
      tick;
    end
    d2ic_valid = 1'b0;
    #1 chk("b2b_last", 32'(ic2ex_valid), 1);
    chk("b2b_last_rd", 32'(ic2sb_rd_num), 4);
    tick;
    chk("b2b_idle", 32'(ic2ex_valid), 0);
    // reset mid-stall drops the packet
    sb_reg = 32'h8;
    pkt(40'h3, 8'h01, 8'hFF, 20'h9, 4'b0001, 4'b0000);
    d2ic_valid = 1'b1;
    tick;
    d2ic_valid = 1'b0;
    #1 chk("rs_stall", 32'(ic2ctl_stall), 1);
    rst_n = 1'b0;
    tick;
    chk("rs_valid", 32'(ic2ex_valid), 0);
    chk("rs_ready", 32'(ic2d_ready), 1);
    chk("rs_rd_num", 32'(ic2sb_rd_num), 0);
    chk("rs_we", 32'({ic2sb_rd_we, ic2sb_pred_we}), 0);
    chk("rs_stall0", 32'(ic2ctl_stall), 0);
    chk("rs_perf", ic2ctl_stall_cycles, 0);
    rst_n = 1'b1;
    sb_reg = '0;
    #1 chk("rs_noissue", 32'(ic2ex_valid), 0);
    tick;
    chk("rs_noissue2", 32'(ic2ex_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
